// File: rtl/fe_prefetch_buf_pkg.sv
// Shared fetch-stage definitions: line geometry, counter sizing and the fetch FSM states.
package fe_prefetch_buf_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = 128;
  localparam int OFF_W      = 4;

  // Back-to-back redirects against a stalled I-cache can leave more than two
  // stale lines outstanding, so the credit counters are wider than the buffer.
  localparam int                CNT_W        = 3;
  localparam logic [CNT_W-1:0] MAX_INFLIGHT = 3'd7;

  typedef enum logic {
    FETCH    = 1'b0,
    EXP_HOLD = 1'b1
  } fe_state_e;

endpackage

// File: rtl/fe_prefetch_buf_byte_align.sv
// Byte shifter: selects 16 consecutive bytes out of a 32-byte pair starting at byte off.
module fe_byte_align
  import fe_prefetch_buf_pkg::*;
(
  input  logic [2*LINE_W-1:0] data,
  input  logic [OFF_W-1:0]    off,
  output logic [LINE_W-1:0]   bytes
);

  logic [2*LINE_W-1:0] shifted;

  assign shifted = data >> {off, 3'b000};
  assign bytes   = shifted[LINE_W-1:0];

endmodule

// File: rtl/fe_prefetch_buf.sv
// Fetch prefetch buffer: keeps two 16-byte lines ahead of decode and presents a
// 16-byte window at the current EIP; writeback redirects flush and refetch.
module fe_prefetch_buf
  import fe_prefetch_buf_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_wb_redirect,
  input  logic [31:0]   w_wb_redirect_eip,
  output logic          o_ic_req,
  output logic [31:0]   o_ic_addr,
  input  logic          i_ic_ready,
  input  logic          i_ic_rsp_valid,
  input  logic [127:0]  i_ic_rsp_data,
  input  logic          i_ic_rsp_exp,
  output logic          o_fe_valid,
  output logic [127:0]  o_fe_bytes,
  output logic [31:0]   o_fe_eip,
  output logic          o_fe_exp,
  input  logic          i_de_consume,
  input  logic [3:0]    i_de_len
);

  localparam logic [31:0]    RESET_BASE   = {RESET_EIP[31:4], 4'h0};
  localparam logic [CNT_W:0] CREDIT_LINES = 2;

  fe_state_e         state, state_n;
  logic [LINE_W-1:0] line0, line1;
  logic              exp0, exp1;
  logic [1:0]        nlines;
  logic [31:0]       base, req_addr;
  logic [OFF_W-1:0]  off;
  logic [CNT_W-1:0]  inflight, drop;

  logic              accept, consume, pop, rsp_keep, rsp_drop, wr_hi;
  logic [4:0]        sum;
  logic [CNT_W:0]    credit_used;
  logic [CNT_W-1:0]  acc_cnt, rsp_cnt, drop_cnt;
  logic [31:0]       redirect_base;

  // Lines still to arrive after stale responses are discarded count against the buffer.
  assign credit_used = {2'b00, nlines} + {1'b0, inflight} - {1'b0, drop};

  assign o_ic_req  = ~rst & (state == FETCH) & (credit_used < CREDIT_LINES) &
                     (inflight < MAX_INFLIGHT) & ~w_wb_redirect;
  assign o_ic_addr = req_addr;
  assign accept    = o_ic_req & i_ic_ready;

  assign o_fe_valid = (nlines == 2'd2) | ((nlines != 2'd0) & exp0);
  assign o_fe_eip   = base + {28'b0, off};
  assign o_fe_exp   = (nlines != 2'd0) & (exp0 | ((nlines == 2'd2) & exp1));

  assign consume  = o_fe_valid & i_de_consume;
  assign sum      = {1'b0, off} + {1'b0, i_de_len};
  assign pop      = consume & sum[4];
  assign rsp_drop = i_ic_rsp_valid & (drop != '0);
  assign rsp_keep = i_ic_rsp_valid & (drop == '0);
  // A same-cycle pop frees slot 0, so the arriving line lands one slot lower.
  assign wr_hi    = (nlines - {1'b0, pop}) == 2'd1;

  assign acc_cnt       = {{(CNT_W-1){1'b0}}, accept};
  assign rsp_cnt       = {{(CNT_W-1){1'b0}}, i_ic_rsp_valid};
  assign drop_cnt      = {{(CNT_W-1){1'b0}}, rsp_drop};
  assign redirect_base = {w_wb_redirect_eip[31:4], 4'h0};

  fe_byte_align u_align (
    .data  ({line1, line0}),
    .off   (off),
    .bytes (o_fe_bytes)
  );

  always_comb begin
    state_n = state;
    if (w_wb_redirect) begin
      state_n = FETCH;
    end else if ((state == FETCH) && rsp_keep && i_ic_rsp_exp) begin
      state_n = EXP_HOLD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nlines   <= '0;
      inflight <= '0;
      drop     <= '0;
      base     <= RESET_BASE;
      req_addr <= RESET_BASE;
      off      <= RESET_EIP[3:0];
    end else if (w_wb_redirect) begin
      // Everything still outstanding after this cycle's response is stale.
      nlines   <= '0;
      inflight <= inflight - rsp_cnt;
      drop     <= inflight - rsp_cnt;
      base     <= redirect_base;
      req_addr <= redirect_base;
      off      <= w_wb_redirect_eip[3:0];
    end else begin
      nlines   <= nlines - {1'b0, pop} + {1'b0, rsp_keep};
      inflight <= inflight + acc_cnt - rsp_cnt;
      drop     <= drop - drop_cnt;
      if (accept) req_addr <= req_addr + 32'd16;
      if (consume) off <= sum[3:0];
      if (pop) base <= base + 32'd16;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_wb_redirect) begin
      if (pop) begin
        line0 <= line1;
        exp0  <= exp1;
      end
      if (rsp_keep && wr_hi) begin
        line1 <= i_ic_rsp_data;
        exp1  <= i_ic_rsp_exp;
      end
      if (rsp_keep && !wr_hi) begin
        line0 <= i_ic_rsp_data;
        exp0  <= i_ic_rsp_exp;
      end
    end
  end

  a_rsp_credit: assert property (@(posedge clk) disable iff (rst)
    i_ic_rsp_valid |-> (inflight != '0))
    else $error("I-cache response with nothing in flight");

  a_len_nonzero: assert property (@(posedge clk) disable iff (rst)
    (o_fe_valid && i_de_consume) |-> (i_de_len != 4'd0))
    else $error("decode consumed a zero-length instruction");

endmodule
